// File: rtl/qsys_sampler.sv
// qsys_sampler: capture side of the sampler/player pair.
// Records one sample per clk into a 2**timeBits-deep buffer, either immediately
// on arm or on a rising edge of a selected input bit. Software reads samples
// back over an Avalon-MM buffer slave and controls capture through one CSR.
module qsys_sampler #(
    parameter int inputBits = 32,
    parameter int timeBits  = 10
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [inputBits-1:0] s_in,
    input  logic                 buffer_read,
    input  logic [timeBits-1:0]  buffer_address,
    output logic [31:0]          buffer_readdata,
    output logic                 buffer_readdatavalid,
    input  logic                 csr_write,
    input  logic [31:0]          csr_writedata,
    input  logic                 csr_read,
    output logic [31:0]          csr_readdata,
    output logic                 irq
);

    localparam int DEPTH = 1 << timeBits;
    // Index of the final sample; reaching it in CAPTURE ends the run.
    localparam logic [timeBits:0] LAST_IDX = {1'b0, {timeBits{1'b1}}};
    localparam logic [timeBits:0] ONE_CNT  = {{timeBits{1'b0}}, 1'b1};
    localparam logic [timeBits:0] ZERO_CNT = {(timeBits + 1){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                state_r;
    state_t                next_state_s;
    logic [timeBits:0]     count_r;
    logic [timeBits:0]     count_next_s;
    logic                  prev_r;
    logic                  trig_en_r;
    logic [4:0]            trig_sel_r;
    logic                  irq_r;
    logic                  irq_set_s;
    logic                  sel_bit_s;
    logic                  edge_s;
    logic                  mem_we_s;
    logic [timeBits-1:0]   mem_addr_s;
    logic [31:0]           status_s;
    logic [31:0]           rd_ext_s;
    logic [31:0]           csr_readdata_r;
    logic [31:0]           buffer_readdata_r;
    logic                  buffer_readdatavalid_r;
    logic [inputBits-1:0]  mem_r [DEPTH];

    // Select the trigger bit; out-of-range selections fall back to bit 0.
    always_comb begin
        sel_bit_s = s_in[0];
        for (int i = 0; i < inputBits; i++) begin
            sel_bit_s = (trig_sel_r == 5'(i)) ? s_in[i] : sel_bit_s;
        end
        edge_s = ~prev_r & sel_bit_s;
    end

    // Next-state, sample-write and irq-set decode; disarm outranks everything.
    always_comb begin
        next_state_s = state_r;
        count_next_s = count_r;
        mem_we_s     = 1'b0;
        mem_addr_s   = count_r[timeBits-1:0];
        irq_set_s    = 1'b0;
        if (csr_write && !csr_writedata[0]) begin
            next_state_s = ST_IDLE;
        end else if (csr_write && (state_r == ST_IDLE || state_r == ST_DONE)) begin
            count_next_s = ZERO_CNT;
            next_state_s = csr_writedata[3] ? ST_WAIT : ST_CAPTURE;
        end else begin
            // A re-arm while WAIT/CAPTURE lands here and the run simply continues.
            case (state_r)
                ST_WAIT: begin
                    if (edge_s) begin
                        mem_we_s     = 1'b1;
                        mem_addr_s   = {timeBits{1'b0}};
                        count_next_s = ONE_CNT;
                        next_state_s = ST_CAPTURE;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end
                ST_CAPTURE: begin
                    mem_we_s     = 1'b1;
                    count_next_s = count_r + ONE_CNT;
                    if (count_r == LAST_IDX) begin
                        next_state_s = ST_DONE;
                        irq_set_s    = 1'b1;
                    end else begin
                        next_state_s = ST_CAPTURE;
                    end
                end
                default: begin
                    next_state_s = state_r;
                end
            endcase
        end
    end

    // CSR status word and zero-extended buffer sample.
    always_comb begin
        status_s                     = 32'd0;
        status_s[0]                  = (state_r != ST_IDLE);
        status_s[1]                  = (state_r == ST_DONE);
        status_s[2]                  = irq_r;
        status_s[3]                  = trig_en_r;
        status_s[12:8]               = trig_sel_r;
        status_s[16 +: timeBits + 1] = count_r;
        rd_ext_s                     = 32'd0;
        rd_ext_s[inputBits-1:0]      = mem_r[buffer_address];
    end

    // Control state: FSM, sample count, edge history, trigger config, irq.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            count_r    <= ZERO_CNT;
            prev_r     <= 1'b0;
            trig_en_r  <= 1'b0;
            trig_sel_r <= 5'd0;
            irq_r      <= 1'b0;
        end else begin
            state_r <= next_state_s;
            count_r <= count_next_s;
            prev_r  <= sel_bit_s;
            if (csr_write) begin
                trig_en_r  <= csr_writedata[3];
                trig_sel_r <= csr_writedata[12:8];
            end
            // Completion wins over a clearing write in the same clk.
            if (irq_set_s) begin
                irq_r <= 1'b1;
            end else if (csr_write) begin
                irq_r <= 1'b0;
            end
        end
    end

    // CSR readback; a simultaneous write suppresses the read update.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csr_readdata_r <= 32'd0;
        end else if (csr_read && !csr_write) begin
            csr_readdata_r <= status_s;
        end
    end

    // Buffer readback with fixed one-clk latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buffer_readdata_r      <= 32'd0;
            buffer_readdatavalid_r <= 1'b0;
        end else begin
            buffer_readdatavalid_r <= buffer_read;
            if (buffer_read) begin
                buffer_readdata_r <= rd_ext_s;
            end
        end
    end

    // Sample storage; contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= s_in;
        end
    end

    assign csr_readdata         = csr_readdata_r;
    assign irq                  = irq_r;
    assign buffer_readdata      = buffer_readdata_r;
    assign buffer_readdatavalid = buffer_readdatavalid_r;

endmodule

// File: tb/tb_qsys_sampler.sv
// Directed testbench for qsys_sampler (inputBits=8, timeBits=4).
module tb_qsys_sampler;

    logic        clk;
    logic        reset_n;
    logic [7:0]  s_in;
    logic        buffer_read;
    logic [3:0]  buffer_address;
    logic [31:0] buffer_readdata;
    logic        buffer_readdatavalid;
    logic        csr_write;
    logic [31:0] csr_writedata;
    logic        csr_read;
    logic [31:0] csr_readdata;
    logic        irq;

    int          checks;
    int          errors;
    logic        auto_inc;
    logic [7:0]  first;
    logic [7:0]  exp_byte;

    qsys_sampler #(.inputBits(8), .timeBits(4)) dut (
        .clk                  (clk),
        .reset_n              (reset_n),
        .s_in                 (s_in),
        .buffer_read          (buffer_read),
        .buffer_address       (buffer_address),
        .buffer_readdata      (buffer_readdata),
        .buffer_readdatavalid (buffer_readdatavalid),
        .csr_write            (csr_write),
        .csr_writedata        (csr_writedata),
        .csr_read             (csr_read),
        .csr_readdata         (csr_readdata),
        .irq                  (irq)
    );

    // 100 MHz-style free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One clock: wait for the edge, then move 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
        if (auto_inc) s_in = s_in + 8'd1;
    endtask

    task automatic csr_wr(input logic [31:0] wd);
        csr_write     = 1'b1;
        csr_writedata = wd;
        step();
        csr_write     = 1'b0;
    endtask

    task automatic csr_rd_check(input string tag, input logic [31:0] exp);
        csr_read = 1'b1;
        step();
        csr_read = 1'b0;
        check(tag, csr_readdata, exp);
    endtask

    task automatic buf_rd_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        buffer_read    = 1'b1;
        buffer_address = addr;
        step();
        buffer_read    = 1'b0;
        check({tag, "_valid"}, {31'd0, buffer_readdatavalid}, 32'd1);
        check({tag, "_data"}, buffer_readdata, exp);
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        auto_inc       = 1'b0;
        reset_n        = 1'b0;
        s_in           = 8'h20;
        buffer_read    = 1'b0;
        buffer_address = 4'd0;
        csr_write      = 1'b0;
        csr_writedata  = 32'd0;
        csr_read       = 1'b0;
        first          = 8'd0;
        exp_byte       = 8'd0;

        // Reset state
        step();
        step();
        check("rst_csr", csr_readdata, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_rdv", {31'd0, buffer_readdatavalid}, 32'd0);
        check("rst_rdata", buffer_readdata, 32'd0);
        reset_n = 1'b1;
        step();

        // 1: untriggered capture of a counting input
        auto_inc = 1'b1;
        csr_wr(32'h0000_0001);
        first = s_in;
        repeat (15) step();
        check("t1_irq_before_last", {31'd0, irq}, 32'd0);
        step();
        check("t1_irq_done", {31'd0, irq}, 32'd1);
        csr_rd_check("t1_status", 32'h0010_0007);

        // 6: back-to-back buffer reads, upper bits zero
        buffer_read = 1'b1;
        for (int k = 0; k < 3; k++) begin
            buffer_address = 4'(k);
            step();
            exp_byte = first + 8'(k);
            check("t6_b2b_valid", {31'd0, buffer_readdatavalid}, 32'd1);
            check("t6_b2b_data", buffer_readdata, {24'd0, exp_byte});
        end
        buffer_read = 1'b0;
        step();
        check("t6_valid_drop", {31'd0, buffer_readdatavalid}, 32'd0);
        exp_byte = first + 8'd15;
        buf_rd_check("t1_last_sample", 4'd15, {24'd0, exp_byte});

        // 4: re-arm from DONE clears irq; re-arm coinciding with completion keeps it
        csr_wr(32'h0000_0001);
        check("t4_irq_clear", {31'd0, irq}, 32'd0);
        csr_rd_check("t4_status_rearm", 32'h0000_0001);
        repeat (14) step();
        check("t4_irq_pre", {31'd0, irq}, 32'd0);
        csr_wr(32'h0000_0001);
        check("t4_set_wins", {31'd0, irq}, 32'd1);
        csr_rd_check("t4_status_done", 32'h0010_0007);

        // 2: trigger on bit 3 rising edge
        auto_inc = 1'b0;
        s_in     = 8'h00;
        csr_wr(32'h0000_0309);
        check("t2_irq_clear", {31'd0, irq}, 32'd0);
        repeat (10) step();
        csr_rd_check("t2_wait_status", 32'h0000_0309);
        repeat (8) step();
        s_in = 8'h0C;
        step();
        s_in = 8'h55;
        step();
        csr_rd_check("t2_capture_status", 32'h0002_0309);
        buf_rd_check("t2_trigger_sample", 4'd0, 32'h0000_000C);
        buf_rd_check("t2_second_sample", 4'd1, 32'h0000_0055);

        // 3: abort after 5 samples
        csr_wr(32'h0000_0000);
        auto_inc = 1'b1;
        s_in     = 8'h80;
        csr_wr(32'h0000_0001);
        first = s_in;
        repeat (5) step();
        csr_wr(32'h0000_0000);
        check("t3_irq", {31'd0, irq}, 32'd0);
        csr_rd_check("t3_status", 32'h0005_0000);
        csr_write     = 1'b1;
        csr_writedata = 32'h0000_0308;
        csr_read      = 1'b1;
        step();
        csr_write     = 1'b0;
        csr_read      = 1'b0;
        check("t3_wr_rd_hold", csr_readdata, 32'h0005_0000);
        csr_rd_check("t3_status_cfg", 32'h0005_0308);
        for (int k = 0; k < 5; k++) begin
            exp_byte = first + 8'(k);
            buf_rd_check("t3_sample", 4'(k), {24'd0, exp_byte});
        end

        // 5: asynchronous reset mid-capture
        s_in = 8'h40;
        csr_wr(32'h0000_0001);
        first = s_in;
        repeat (3) step();
        csr_rd_check("t5_status_cap", 32'h0003_0001);
        buf_rd_check("t5_pre_reset", 4'd0, {24'd0, first});
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_async_csr", csr_readdata, 32'd0);
        check("t5_async_rdata", buffer_readdata, 32'd0);
        check("t5_async_rdv", {31'd0, buffer_readdatavalid}, 32'd0);
        check("t5_async_irq", {31'd0, irq}, 32'd0);
        #1;
        reset_n = 1'b1;
        step();
        csr_rd_check("t5_disarmed", 32'h0000_0000);
        check("t5_rdv_idle", {31'd0, buffer_readdatavalid}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
